// File: rtl/night_rider_ctrl.sv
// rtl/night_rider_ctrl.sv - run/pause/step scheduler for the LED scanner
module night_rider_ctrl #(
    parameter int N        = 8,
    parameter int DIV_W    = 16,
    parameter int SWEEP_W  = 8,
    parameter int DEF_RATE = 0,
    localparam int PW      = $clog2(N)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [1:0]         cmd_op,
    input  logic [DIV_W-1:0]   cmd_arg,
    output logic               step,
    output logic               dir,
    output logic [PW-1:0]      pos,
    output logic               sweep_done,
    output logic [SWEEP_W-1:0] sweep_cnt,
    output logic               busy
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_RUN    = 2'd1;
    localparam logic [1:0] ST_SINGLE = 2'd2;

    localparam logic [1:0] OP_STOP = 2'd0;
    localparam logic [1:0] OP_RUN  = 2'd1;
    localparam logic [1:0] OP_STEP = 2'd2;
    localparam logic [1:0] OP_LOAD = 2'd3;

    localparam logic [PW-1:0]      POS_MAX = PW'(N - 1);
    localparam logic [SWEEP_W-1:0] SW_ONE  = SWEEP_W'(1);
    localparam logic [SWEEP_W-1:0] SW_MAX  = '1;

    logic [1:0]         state;
    logic [DIV_W-1:0]   rate;
    logic [DIV_W-1:0]   cnt;
    logic [SWEEP_W-1:0] limit;
    logic [SWEEP_W-1:0] run_sw;
    logic [SWEEP_W-1:0] run_sw_inc;

    logic          accept;
    logic          in_run;
    logic          tick;
    logic          stop_now;
    logic          rerun;
    logic          adv;
    logic          at_end;
    logic          limit_hit;
    logic [PW-1:0] nxt;

    assign cmd_ready = (state != ST_SINGLE);
    assign busy      = (state == ST_RUN);

    always_comb begin
        accept     = cmd_valid && cmd_ready;
        in_run     = (state == ST_RUN);
        tick       = in_run && (cnt == rate);
        stop_now   = in_run && accept && (cmd_op == OP_STOP);
        rerun      = in_run && accept && (cmd_op == OP_RUN);
        // STOP accepted in a tick cycle suppresses that advance.
        adv        = (state == ST_SINGLE) || (tick && !stop_now);
        nxt        = dir ? pos + PW'(1) : pos - PW'(1);
        at_end     = (nxt == '0) || (nxt == POS_MAX);
        run_sw_inc = run_sw + SW_ONE;
        // A RUN arriving with the limiting endpoint restarts the count instead.
        limit_hit  = in_run && adv && at_end && (limit != '0) &&
                     (run_sw_inc == limit) && !rerun;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept && cmd_op == OP_RUN)
                        state <= ST_RUN;
                    else if (accept && cmd_op == OP_STEP)
                        state <= ST_SINGLE;
                end
                ST_RUN: begin
                    if (stop_now || limit_hit)
                        state <= ST_IDLE;
                end
                ST_SINGLE: state <= ST_IDLE;
                default:   state <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rate <= DIV_W'(DEF_RATE);
            cnt  <= '0;
        end else begin
            if (accept && cmd_op == OP_LOAD)
                rate <= cmd_arg;
            if (!in_run)
                cnt <= '0;
            else if (accept && cmd_op != OP_STEP)
                cnt <= '0;
            else if (tick)
                cnt <= '0;
            else
                cnt <= cnt + DIV_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            limit  <= '0;
            run_sw <= '0;
        end else if (accept && cmd_op == OP_RUN) begin
            limit  <= cmd_arg[SWEEP_W-1:0];
            run_sw <= '0;
        end else if (adv && at_end) begin
            run_sw <= run_sw_inc;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pos        <= '0;
            dir        <= 1'b1;
            step       <= 1'b0;
            sweep_done <= 1'b0;
            sweep_cnt  <= '0;
        end else begin
            step       <= adv;
            sweep_done <= adv && at_end;
            if (adv) begin
                pos <= nxt;
                if (nxt == POS_MAX)
                    dir <= 1'b0;
                else if (nxt == '0)
                    dir <= 1'b1;
                if (at_end && sweep_cnt != SW_MAX)
                    sweep_cnt <= sweep_cnt + SW_ONE;
            end
        end
    end

endmodule

// File: tb/tb_night_rider_ctrl.sv
// tb/tb_night_rider_ctrl.sv - scoreboard bench for night_rider_ctrl
module tb_night_rider_ctrl;

    localparam int N       = 8;
    localparam int DIV_W   = 16;
    localparam int SWEEP_W = 2;
    localparam int SC_MAX  = 3;

    localparam logic [1:0] OP_STOP = 2'd0;
    localparam logic [1:0] OP_RUN  = 2'd1;
    localparam logic [1:0] OP_STEP = 2'd2;
    localparam logic [1:0] OP_LOAD = 2'd3;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               cmd_valid = 1'b0;
    logic               cmd_ready;
    logic [1:0]         cmd_op = 2'd0;
    logic [DIV_W-1:0]   cmd_arg = '0;
    logic               step;
    logic               dir;
    logic [2:0]         pos;
    logic               sweep_done;
    logic [SWEEP_W-1:0] sweep_cnt;
    logic               busy;

    night_rider_ctrl #(.N(N), .DIV_W(DIV_W), .SWEEP_W(SWEEP_W), .DEF_RATE(0)) dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_arg(cmd_arg), .step(step), .dir(dir), .pos(pos),
        .sweep_done(sweep_done), .sweep_cnt(sweep_cnt), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int cyc;
        int pos;
        int dir;
        int sd;
        int sc;
        int busy;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;
    int   m_pos = 0;
    int   m_dir = 1;
    int   m_sc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cyc %0d)", tag, got, exp, cyc);
        end
    endtask

    // Scoreboard side: every observed step must match the next queued prediction.
    always @(negedge clk) begin
        if (!rst) begin
            if (step) begin
                if (sb.size() == 0) begin
                    chk("unexpected_step", 1, 0);
                end else begin
                    e = sb.pop_front();
                    chk("step_cyc", cyc, e.cyc);
                    chk("step_pos", int'(pos), e.pos);
                    chk("step_dir", int'(dir), e.dir);
                    chk("step_sweep_done", int'(sweep_done), e.sd);
                    chk("step_sweep_cnt", int'(sweep_cnt), e.sc);
                    chk("step_busy", int'(busy), e.busy);
                end
            end else begin
                chk("quiet_sweep_done", int'(sweep_done), 0);
            end
        end
    end

    task automatic push_steps(input int first, input int period, input int n,
                              input int bsy, input int last_bsy);
        exp_t x;
        int nxt;
        for (int k = 0; k < n; k++) begin
            nxt = (m_dir != 0) ? m_pos + 1 : m_pos - 1;
            x.sd = (nxt == 0 || nxt == N - 1) ? 1 : 0;
            if (nxt == N - 1) m_dir = 0;
            if (nxt == 0) m_dir = 1;
            if (x.sd != 0 && m_sc < SC_MAX) m_sc++;
            m_pos  = nxt;
            x.cyc  = first + k * period;
            x.pos  = m_pos;
            x.dir  = m_dir;
            x.sc   = m_sc;
            x.busy = (k == n - 1) ? last_bsy : bsy;
            sb.push_back(x);
        end
    endtask

    task automatic send(input logic [1:0] op, input logic [DIV_W-1:0] arg, output int t);
        cmd_op    = op;
        cmd_arg   = arg;
        cmd_valid = 1'b1;
        t         = cyc;
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic wait_cyc(input int target);
        while (cyc < target) @(negedge clk);
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_cmd_ready"}, int'(cmd_ready), 1);
        chk({tag, "_pos"}, int'(pos), 0);
        chk({tag, "_dir"}, int'(dir), 1);
        chk({tag, "_busy"}, int'(busy), 0);
        chk({tag, "_step"}, int'(step), 0);
        chk({tag, "_sweep_done"}, int'(sweep_done), 0);
        chk({tag, "_sweep_cnt"}, int'(sweep_cnt), 0);
    endtask

    // Asserts rst between clock edges and checks outputs before the next edge.
    task automatic do_reset();
        #2;
        chk("sb_empty_pre_rst", sb.size(), 0);
        rst = 1'b1;
        #1;
        check_reset_values("async_rst");
        sb.delete();
        m_pos = 0;
        m_dir = 1;
        m_sc  = 0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int t;
        int t2;

        repeat (2) @(negedge clk);
        rst = 1'b0;
        check_reset_values("por");

        // Rate 2, unlimited run: a full round trip then STOP.
        send(OP_LOAD, 16'd2, t);
        send(OP_RUN, 16'd0, t);
        push_steps(t + 4, 3, 14, 1, 1);
        chk("run_busy_t1", int'(busy), 1);
        wait_cyc(t + 4 + 13 * 3);
        send(OP_STOP, 16'd0, t2);
        chk("stop_busy", int'(busy), 0);
        wait_cyc(cyc + 8);
        chk("r2_sb_empty", sb.size(), 0);
        chk("r2_sweep_cnt", int'(sweep_cnt), 2);
        chk("r2_pos", int'(pos), 0);
        chk("r2_dir", int'(dir), 1);

        // Limited run of two sweeps at rate 0.
        do_reset();
        send(OP_RUN, 16'd2, t);
        push_steps(t + 2, 1, 14, 1, 0);
        wait_cyc(t + 2 + 13 + 6);
        chk("lim_busy", int'(busy), 0);
        chk("lim_sb_empty", sb.size(), 0);
        chk("lim_pos", int'(pos), 0);
        chk("lim_sweep_cnt", int'(sweep_cnt), 2);

        // Single steps from IDLE.
        for (int i = 0; i < 3; i++) begin
            push_steps(cyc + 2, 1, 1, 0, 0);
            send(OP_STEP, 16'd0, t);
            chk("single_ready_low", int'(cmd_ready), 0);
            chk("single_busy", int'(busy), 0);
            @(negedge clk);
            chk("single_ready_back", int'(cmd_ready), 1);
            chk("single_step", int'(step), 1);
            chk("single_pos", int'(pos), i + 1);
        end

        // STOP landing on a tick cycle, then resume.
        send(OP_LOAD, 16'd2, t);
        send(OP_RUN, 16'd0, t);
        push_steps(t + 4, 3, 2, 1, 1);
        wait_cyc(t + 9);
        send(OP_STOP, 16'd0, t2);
        chk("tickstop_step", int'(step), 0);
        chk("tickstop_busy", int'(busy), 0);
        chk("tickstop_pos", int'(pos), 5);
        chk("tickstop_dir", int'(dir), 1);
        wait_cyc(cyc + 5);
        chk("tickstop_hold_pos", int'(pos), 5);
        send(OP_RUN, 16'd0, t2);
        push_steps(t2 + 4, 3, 1, 1, 1);
        wait_cyc(t2 + 4);
        chk("resume_pos", int'(pos), 6);
        chk("resume_dir", int'(dir), 1);
        send(OP_STOP, 16'd0, t);
        wait_cyc(cyc + 6);
        chk("resume_sb_empty", sb.size(), 0);

        // Sweep counter saturation, then reset in the middle of a run.
        do_reset();
        send(OP_RUN, 16'd0, t);
        push_steps(t + 2, 1, 35, 1, 1);
        wait_cyc(t + 2 + 34);
        chk("sat_sweep_cnt", int'(sweep_cnt), SC_MAX);
        chk("sat_busy", int'(busy), 1);
        do_reset();
        wait_cyc(cyc + 4);
        chk("post_rst_busy", int'(busy), 0);
        chk("post_rst_pos", int'(pos), 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
